// File: rtl/axil_uart_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to simpleuart bridge.
// Holds the bus widths, register offsets (addr[3:2]), STATUS bit positions,
// the control FSM state enum and a STATUS word builder.
package axil_uart_bridge_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    // Register offsets as seen on addr[3:2]
    localparam logic [1:0] REG_DIV    = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int unsigned STATUS_FULL_BIT  = 10;
    localparam int unsigned STATUS_EMPTY_BIT = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WSTALL,
        ST_BRESP,
        ST_RRESP
    } state_t;

    // STATUS = {21'b0, full, empty, 1'b0, count[7:0]}
    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic [7:0] count);
        logic [31:0] word;
        word                   = 32'(count);
        word[STATUS_FULL_BIT]  = full;
        word[STATUS_EMPTY_BIT] = empty;
        return word;
    endfunction

endpackage

// File: rtl/axil_uart_bridge_if.sv
// AXI4-Lite bus (aw/w/b/ar/r channels, 32-bit address/data, 4-bit strobe).
// master modport drives requests; slave modport drives ready/response.
interface axi_interf;
    import axil_uart_bridge_pkg::*;

    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_uart_bridge_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
// Ports: clk, reset (sync, active-high), push/din, pop, full, empty, count, head.
// Push at full and pop at empty are ignored; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointer/occupancy tracking; push+pop together leaves count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push != do_pop) count <= do_push ? count + CNT_W'(1) : count - CNT_W'(1);
        end
    end

    // Storage is not reset; consumers qualify head with empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axil_uart_bridge.sv
// AXI4-Lite slave front-end for the simpleuart register block.
// Ports: clk, reset (sync, active-high); uart_axi (AXI4-Lite slave);
// reg_div_we/di/do (divider register); reg_dat_we/re/di/do/wait (data register).
// DATA writes queue bytes in a TX FIFO that drains into reg_dat_di whenever
// simpleuart is not busy; reads of DATA pop the UART receive buffer.
module axil_uart_bridge
    import axil_uart_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    axi_interf.slave    uart_axi,
    output logic [3:0]  reg_div_we,
    output logic [31:0] reg_div_di,
    input  logic [31:0] reg_div_do,
    output logic        reg_dat_we,
    output logic        reg_dat_re,
    output logic [31:0] reg_dat_di,
    input  logic [31:0] reg_dat_do,
    input  logic        reg_dat_wait
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       stall_byte;
    logic             stall_load;
    logic [31:0]      rdata_q;
    logic [31:0]      rd_mux;
    logic             aw_ready;
    logic             ar_ready;
    logic             dat_re;
    logic [3:0]       div_we;
    logic [31:0]      div_di;
    logic             fifo_push;
    logic [7:0]       fifo_din;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_head;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{uart_axi.awaddr[31:4], uart_axi.awaddr[1:0],
                                uart_axi.araddr[31:4], uart_axi.araddr[1:0]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // Drain: present head while non-empty, consume when simpleuart is not busy
    assign reg_dat_we = !fifo_empty;
    assign reg_dat_di = fifo_empty ? 32'h0 : 32'(fifo_head);
    assign fifo_pop   = !fifo_empty && !reg_dat_wait;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake decode; a write with both aw and w present wins over a read
    always_comb begin
        state_d    = state_q;
        aw_ready   = 1'b0;
        ar_ready   = 1'b0;
        dat_re     = 1'b0;
        div_we     = '0;
        div_di     = '0;
        fifo_push  = 1'b0;
        fifo_din   = uart_axi.wdata[7:0];
        stall_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (uart_axi.awvalid && uart_axi.wvalid) begin
                    aw_ready = 1'b1;
                    state_d  = ST_BRESP;
                    case (uart_axi.awaddr[3:2])
                        REG_DIV: begin
                            div_we = uart_axi.wstrb;
                            div_di = uart_axi.wdata;
                        end
                        REG_DATA: begin
                            if (fifo_full) begin
                                stall_load = 1'b1;
                                state_d    = ST_WSTALL;
                            end else begin
                                fifo_push = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else if (!uart_axi.awvalid && !uart_axi.wvalid && uart_axi.arvalid) begin
                    ar_ready = 1'b1;
                    dat_re   = (uart_axi.araddr[3:2] == REG_DATA);
                    state_d  = ST_RRESP;
                end
            end
            ST_WSTALL: begin
                fifo_din = stall_byte;
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    state_d   = ST_BRESP;
                end
            end
            ST_BRESP: if (uart_axi.bready) state_d = ST_IDLE;
            ST_RRESP: if (uart_axi.rready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read data source by register offset
    always_comb begin
        rd_mux = 32'h0;
        case (uart_axi.araddr[3:2])
            REG_DIV:    rd_mux = reg_div_do;
            REG_DATA:   rd_mux = reg_dat_do;
            REG_STATUS: rd_mux = status_word(fifo_full, fifo_empty, 8'(fifo_count));
            REG_RSVD:   rd_mux = 32'h0;
            default:    rd_mux = 32'h0;
        endcase
    end

    // Stalled TX byte and captured read data
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_byte <= '0;
            rdata_q    <= '0;
        end else begin
            if (stall_load) stall_byte <= uart_axi.wdata[7:0];
            if (ar_ready)   rdata_q    <= rd_mux;
        end
    end

    assign uart_axi.awready = aw_ready;
    assign uart_axi.wready  = aw_ready;
    assign uart_axi.bvalid  = (state_q == ST_BRESP);
    assign uart_axi.bresp   = RESP_OKAY;
    assign uart_axi.arready = ar_ready;
    assign uart_axi.rvalid  = (state_q == ST_RRESP);
    assign uart_axi.rresp   = RESP_OKAY;
    assign uart_axi.rdata   = rdata_q;

    assign reg_div_we = div_we;
    assign reg_div_di = div_di;
    assign reg_dat_re = dat_re;

endmodule

// File: tb/tb_axil_uart_bridge.sv
// Directed self-checking bench for axil_uart_bridge.
module tb_axil_uart_bridge;

    logic        clk;
    logic        reset;
    logic [3:0]  reg_div_we;
    logic [31:0] reg_div_di;
    logic [31:0] reg_div_do;
    logic        reg_dat_we;
    logic        reg_dat_re;
    logic [31:0] reg_dat_di;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;

    int tests = 0;
    int fails = 0;
    logic [7:0]  popped [$];
    logic [31:0] rd;

    axi_interf axi ();

    axil_uart_bridge #(.FIFO_DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_axi     (axi),
        .reg_div_we   (reg_div_we),
        .reg_div_di   (reg_div_di),
        .reg_div_do   (reg_div_do),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte simpleuart actually takes (pop condition mid-cycle)
    always @(negedge clk) begin
        if (!reset && reg_dat_we && !reg_dat_wait) popped.push_back(reg_dat_di[7:0]);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit seen;
        axi.awaddr  = addr;
        axi.wdata   = data;
        axi.wstrb   = strb;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            #1; seen = axi.awready && axi.wready;
            @(posedge clk); #1;
        end
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        check("aw_handshake", 32'(seen), 32'h1);
        axi.bready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            #1; seen = axi.bvalid;
            @(posedge clk); #1;
        end
        axi.bready = 1'b0;
        check("b_handshake", 32'(seen), 32'h1);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        bit seen;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            #1; seen = axi.arready;
            @(posedge clk); #1;
        end
        axi.arvalid = 1'b0;
        check("ar_handshake", 32'(seen), 32'h1);
        axi.rready = 1'b1;
        seen = 1'b0;
        data = 32'hx;
        for (int i = 0; i < 200 && !seen; i++) begin
            #1; seen = axi.rvalid;
            if (seen) data = axi.rdata;
            @(posedge clk); #1;
        end
        axi.rready = 1'b0;
        check("r_handshake", 32'(seen), 32'h1);
    endtask

    initial begin
        reset        = 1'b1;
        reg_div_do   = 32'h1234_5678;
        reg_dat_do   = 32'hFFFF_FFFF;
        reg_dat_wait = 1'b0;
        axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_awready", 32'(axi.awready), 32'h0);
        check("rst_bvalid", 32'(axi.bvalid), 32'h0);
        check("rst_rvalid", 32'(axi.rvalid), 32'h0);
        check("rst_rdata", axi.rdata, 32'h0);
        check("rst_dat_we", 32'(reg_dat_we), 32'h0);
        check("rst_dat_di", reg_dat_di, 32'h0);
        check("rst_div_we", 32'(reg_div_we), 32'h0);
        check("rst_div_di", reg_div_di, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // DIV write: strobe and data for the accept cycle only
        axi.awaddr = 32'h0; axi.wdata = 32'h0000_0068; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        #1;
        check("div_awready", 32'(axi.awready), 32'h1);
        check("div_wready", 32'(axi.wready), 32'h1);
        check("div_we_accept", 32'(reg_div_we), 32'hF);
        check("div_di_accept", reg_div_di, 32'h68);
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        #1;
        check("div_we_after", 32'(reg_div_we), 32'h0);
        check("div_bvalid", 32'(axi.bvalid), 32'h1);
        check("div_bresp", 32'(axi.bresp), 32'h0);
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        #1;
        check("div_b_done", 32'(axi.bvalid), 32'h0);

        // DIV read returns divider readback
        axi_read(32'h0, rd);
        check("div_read", rd, 32'h1234_5678);

        // Three DATA writes drain in order
        axi.awaddr = 32'h4; axi.wdata = 32'h0000_0041; axi.wstrb = 4'h1;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        #1;
        check("dat_awready", 32'(axi.awready), 32'h1);
        check("dat_no_div_we", 32'(reg_div_we), 32'h0);
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        check("dat_lat_bvalid", 32'(axi.bvalid), 32'h1);
        check("dat_lat_we", 32'(reg_dat_we), 32'h1);
        check("dat_lat_di", reg_dat_di, 32'h41);
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        axi_write(32'h4, 32'h42, 4'h1);
        axi_write(32'h4, 32'h43, 4'h1);
        repeat (5) @(posedge clk);
        #1;
        check("tx3_count", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            check("tx3_b0", 32'(popped[0]), 32'h41);
            check("tx3_b1", 32'(popped[1]), 32'h42);
            check("tx3_b2", 32'(popped[2]), 32'h43);
        end
        check("tx3_idle_we", 32'(reg_dat_we), 32'h0);
        popped.delete();

        // DATA read: one-cycle read strobe, rdata held while rready low
        reg_dat_do = 32'h0000_005A;
        axi.araddr = 32'h4; axi.arvalid = 1'b1;
        #1;
        check("rx_arready", 32'(axi.arready), 32'h1);
        check("rx_dat_re", 32'(reg_dat_re), 32'h1);
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        reg_dat_do = 32'h0000_0077;
        #1;
        check("rx_dat_re_off", 32'(reg_dat_re), 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("rx_rvalid_hold", 32'(axi.rvalid), 32'h1);
            check("rx_rdata_hold", axi.rdata, 32'h5A);
            @(posedge clk); #1;
        end
        check("rx_rresp", 32'(axi.rresp), 32'h0);
        axi.rready = 1'b1;
        @(posedge clk); #1;
        axi.rready = 1'b0;
        check("rx_r_done", 32'(axi.rvalid), 32'h0);
        reg_dat_do = 32'hFFFF_FFFF;

        // Simultaneous write and read: write first, read after B handshake
        axi.awaddr = 32'h0; axi.wdata = 32'h0000_0099; axi.wstrb = 4'h3;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        axi.araddr = 32'h8; axi.arvalid = 1'b1;
        #1;
        check("sim_awready", 32'(axi.awready), 32'h1);
        check("sim_arready0", 32'(axi.arready), 32'h0);
        check("sim_div_we", 32'(reg_div_we), 32'h3);
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        #1;
        check("sim_bvalid", 32'(axi.bvalid), 32'h1);
        check("sim_arready1", 32'(axi.arready), 32'h0);
        @(posedge clk); #1;
        check("sim_arready2", 32'(axi.arready), 32'h0);
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        #1;
        check("sim_arready3", 32'(axi.arready), 32'h1);
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        check("sim_rvalid", 32'(axi.rvalid), 32'h1);
        check("sim_status", axi.rdata, 32'h0000_0200);
        axi.rready = 1'b1;
        @(posedge clk); #1;
        axi.rready = 1'b0;

        // Fill FIFO with simpleuart busy, then stall the 17th write
        reg_dat_wait = 1'b1;
        for (int i = 0; i < 16; i++) axi_write(32'h4, 32'h10 + 32'(i), 4'h1);
        axi_read(32'h8, rd);
        check("full_status", rd, 32'h0000_0410);
        axi.awaddr = 32'h4; axi.wdata = 32'h0000_0051; axi.wstrb = 4'h1;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        #1;
        check("stall_accept", 32'(axi.awready), 32'h1);
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        check("stall_b0", 32'(axi.bvalid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_b_wait", 32'(axi.bvalid), 32'h0);
        end
        reg_dat_wait = 1'b0;
        @(posedge clk); #1;
        check("stall_b_pop", 32'(axi.bvalid), 32'h0);
        @(posedge clk); #1;
        check("stall_b_push", 32'(axi.bvalid), 32'h1);
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("fill_count", 32'(popped.size()), 32'd17);
        if (popped.size() == 17) begin
            for (int i = 0; i < 16; i++) check($sformatf("fill_b%0d", i), 32'(popped[i]), 32'h10 + 32'(i));
            check("fill_b16", 32'(popped[16]), 32'h51);
        end
        axi_read(32'h8, rd);
        check("drained_status", rd, 32'h0000_0200);
        popped.delete();

        // Reserved offset: write ignored, read zero
        axi_write(32'hC, 32'hDEAD_BEEF, 4'hF);
        axi_read(32'hC, rd);
        check("rsvd_read", rd, 32'h0);

        // Reset while stalled with a full FIFO
        reg_dat_wait = 1'b1;
        for (int i = 0; i < 16; i++) axi_write(32'h4, 32'h20 + 32'(i), 4'h1);
        axi.awaddr = 32'h4; axi.wdata = 32'h0000_0066; axi.wstrb = 4'h1;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        check("rst_stall_b0", 32'(axi.bvalid), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_bvalid", 32'(axi.bvalid), 32'h0);
        check("rst_mid_dat_we", 32'(reg_dat_we), 32'h0);
        check("rst_mid_dat_di", reg_dat_di, 32'h0);
        axi.araddr = 32'h8; axi.arvalid = 1'b1;
        #1;
        check("rst_mid_arready", 32'(axi.arready), 32'h1);
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        check("rst_mid_status", axi.rdata, 32'h0000_0200);
        check("rst_mid_bvalid2", 32'(axi.bvalid), 32'h0);
        axi.rready = 1'b1;
        @(posedge clk); #1;
        axi.rready = 1'b0;
        reg_dat_wait = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_no_tx", 32'(popped.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
